// File: rtl/cam_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cam_match_sequencer
// Description : Serialises a multi-hot CAM match vector into binary row indices,
//               lowest row first, with match count, miss result and drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_match_sequencer #(
    parameter int ROWS   = 8,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   decoded_match_address,
    input  logic              match_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_miss,
    output logic              out_last,
    output logic [ADDR_W:0]   match_count,
    output logic              drop_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_MISS  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROWS-1:0]   r_pending;
    logic [ADDR_W:0]   r_match_count;
    logic              r_drop_err;

    logic              w_accept;
    logic              w_found;
    logic [ADDR_W-1:0] w_low_idx;
    logic [ROWS-1:0]   w_low_onehot;
    logic              w_single;
    logic [ADDR_W:0]   w_popcount;

    assign w_accept = match_valid && (r_state == ST_IDLE);

    // Priority pick of the lowest pending row
    always_comb begin
        w_low_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            if (r_pending[i] && !w_found) begin
                w_low_idx = ADDR_W'(i);
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_popcount = w_popcount + {{ADDR_W{1'b0}}, decoded_match_address[i]};
        end
    end

    assign w_low_onehot = r_pending & (~r_pending + ROWS'(1));
    assign w_single     = (r_pending != '0) && ((r_pending & (r_pending - ROWS'(1))) == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (decoded_match_address != '0) ? ST_DRAIN : ST_MISS;
                end
            end
            ST_DRAIN: begin
                if (out_ready && w_single) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MISS: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_pending     <= '0;
            r_match_count <= '0;
            r_drop_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pending     <= decoded_match_address;
                r_match_count <= w_popcount;
            end else if ((r_state == ST_DRAIN) && out_ready) begin
                r_pending <= r_pending & ~w_low_onehot;
            end
            if (match_valid && (r_state != ST_IDLE)) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // Outputs decode from registered state only, so they stay stable under backpressure
    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state != ST_IDLE);
    assign out_miss    = (r_state == ST_MISS);
    assign out_addr    = (r_state == ST_DRAIN) ? w_low_idx : '0;
    assign out_last    = ((r_state == ST_DRAIN) && w_single) || (r_state == ST_MISS);
    assign match_count = r_match_count;
    assign drop_err    = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_cam_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_match_sequencer
// Description : Directed self-checking bench for cam_match_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_match_sequencer;

    localparam int ROWS   = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic [ROWS-1:0]   decoded_match_address;
    logic              match_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_miss;
    logic              out_last;
    logic [ADDR_W:0]   match_count;
    logic              drop_err;

    int n_vec = 0;
    int n_err = 0;

    cam_match_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .decoded_match_address (decoded_match_address),
        .match_valid           (match_valid),
        .in_ready              (in_ready),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_addr              (out_addr),
        .out_miss              (out_miss),
        .out_last              (out_last),
        .match_count           (match_count),
        .drop_err              (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_vec++;
        if (obs !== exp_val) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_val);
        end
    endtask

    // Offer a vector at the current negedge; it is taken on the next posedge
    task automatic accept(input logic [ROWS-1:0] vec);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        decoded_match_address = vec;
        match_valid           = 1'b1;
        @(negedge clk);
        match_valid           = 1'b0;
    endtask

    // Check the presented result, then let it transfer (out_ready assumed 1)
    task automatic xfer(input string tag, input int addr, input bit last, input bit miss);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_addr"},  32'(out_addr),  32'(addr));
        check({tag, "_last"},  32'(out_last),  32'(last));
        check({tag, "_miss"},  32'(out_miss),  32'(miss));
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst                   = 1'b0;
        match_valid           = 1'b0;
        decoded_match_address = '0;
        out_ready             = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_addr",    32'(out_addr),    32'd0);
        check("rst_out_miss",    32'(out_miss),    32'd0);
        check("rst_out_last",    32'(out_last),    32'd0);
        check("rst_match_count", 32'(match_count), 32'd0);
        check("rst_drop_err",    32'(drop_err),    32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single row
        accept(8'h01);
        check("t1_count", 32'(match_count), 32'd1);
        xfer("t1_a0", 0, 1'b1, 1'b0);
        check_idle("t1_end");

        // Three rows
        accept(8'h70);
        check("t2_count", 32'(match_count), 32'd3);
        xfer("t2_a4", 4, 1'b0, 1'b0);
        xfer("t2_a5", 5, 1'b0, 1'b0);
        xfer("t2_a6", 6, 1'b1, 1'b0);
        check_idle("t2_end");

        // Miss
        accept(8'h00);
        check("t3_count", 32'(match_count), 32'd0);
        xfer("t3_miss", 0, 1'b1, 1'b1);
        check_idle("t3_end");

        // Backpressure
        out_ready = 1'b0;
        accept(8'h82);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_addr",  32'(out_addr),  32'd1);
            check("t4_hold_last",  32'(out_last),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("t4_count", 32'(match_count), 32'd2);
        xfer("t4_a1", 1, 1'b0, 1'b0);
        xfer("t4_a7", 7, 1'b1, 1'b0);
        check_idle("t4_end");

        // All rows, with a dropped vector mid-drain
        accept(8'hFF);
        check("t5_count", 32'(match_count), 32'd8);
        check("t5_drop_pre", 32'(drop_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                decoded_match_address = 8'h01;
                match_valid           = 1'b1;
            end
            xfer("t5_a", i, (i == 7), 1'b0);
            match_valid = 1'b0;
            if (i == 3) begin
                check("t5_drop_err", 32'(drop_err),    32'd1);
                check("t5_count_kept", 32'(match_count), 32'd8);
            end
        end
        check_idle("t5_end");
        check("t5_drop_sticky", 32'(drop_err), 32'd1);

        // Reset mid-drain
        accept(8'h0C);
        check("t6_count", 32'(match_count), 32'd2);
        xfer("t6_a2", 2, 1'b0, 1'b0);
        check("t6_pre_addr", 32'(out_addr), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", 32'(out_valid),   32'd0);
        check("t6_rst_addr",  32'(out_addr),    32'd0);
        check("t6_rst_last",  32'(out_last),    32'd0);
        check("t6_rst_miss",  32'(out_miss),    32'd0);
        check("t6_rst_count", 32'(match_count), 32'd0);
        check("t6_rst_drop",  32'(drop_err),    32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("t6_post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
